// File: rtl/darkriscv_dmem_pkg.sv
// Shared types and constants for the darkriscv data-bus responder.
package darkriscv_dmem_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    READY   = 2'd2
  } state_e;

  localparam logic [2:0]    DLEN_B = 3'b001;
  localparam logic [2:0]    DLEN_H = 3'b010;
  localparam logic [2:0]    DLEN_W = 3'b100;
  localparam logic [DW-1:0] POISON = 32'hDEAD_BEEF;

  // Lane mask for a store; unknown sizes produce no enables.
  function automatic logic [BEW-1:0] byte_en(input logic [2:0] dlen, input logic [1:0] lo);
    case (dlen)
      DLEN_B:  byte_en = 4'b0001 << lo;
      DLEN_H:  byte_en = 4'b0011 << lo;
      DLEN_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/darkriscv_dmem_resp_if.sv
// Core data-port bundle: the core is master, the responder is slave.
interface darkriscv_dmem_resp_if;
  logic        DAS;
  logic        DRD;
  logic        DWR;
  logic [31:0] DADDR;
  logic [31:0] DATAO;
  logic [2:0]  DLEN;
  logic [31:0] DATAI;
  logic        HLT;
  logic        ERR;
  logic [7:0]  ERRCNT;

  modport master (
    output DAS, DRD, DWR, DADDR, DATAO, DLEN,
    input  DATAI, HLT, ERR, ERRCNT
  );

  modport slave (
    input  DAS, DRD, DWR, DADDR, DATAO, DLEN,
    output DATAI, HLT, ERR, ERRCNT
  );
endinterface

// File: rtl/darkriscv_dmem_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module darkriscv_dmem_ram #(
  parameter int unsigned MLEN = 10
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic            re_i,
  input  logic [MLEN-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);
  localparam int unsigned DEPTH = 2 ** MLEN;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/darkriscv_dmem_resp.sv
// Data-bus responder for the darkriscv core: posted writes, wait-stated reads,
// and rejection/counting of malformed or out-of-range accesses.
module darkriscv_dmem_resp
  import darkriscv_dmem_pkg::*;
#(
  parameter int unsigned MLEN = 10,
  parameter int unsigned WAIT = 2,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  RES,
  darkriscv_dmem_resp_if.slave bus
);
  localparam int unsigned CW   = 4;
  localparam logic [32:0] SPAN = 33'(1) << (MLEN + 2);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MLEN-1:0] addr_q, addr_d;
  logic [31:0]     datai_q, datai_d;
  logic            err_q, err_d;
  logic [7:0]      errcnt_q, errcnt_d;

  logic [31:0]     off_c, rdata_c;
  logic [MLEN-1:0] ram_addr_c;
  logic            req_c, bad_c, idle_c, rd_ok_c, wr_ok_c, rej_c, re_c;

  // Request decode; only meaningful while IDLE and out of reset.
  assign off_c   = bus.DADDR - BASE;
  assign req_c   = bus.DAS & (bus.DRD | bus.DWR);
  assign bad_c   = (bus.DRD & bus.DWR)
                 | ~$onehot(bus.DLEN)
                 | ((bus.DLEN == DLEN_H) & bus.DADDR[0])
                 | ((bus.DLEN == DLEN_W) & (bus.DADDR[1:0] != 2'b00))
                 | ({1'b0, off_c} >= SPAN);
  assign idle_c  = RES & (state_q == IDLE);
  assign rd_ok_c = idle_c & req_c & ~bad_c & bus.DRD;
  assign wr_ok_c = idle_c & req_c & ~bad_c & bus.DWR;
  assign rej_c   = idle_c & req_c & bad_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    datai_d  = datai_q;
    err_d    = rej_c;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: begin
        if (rd_ok_c) begin
          addr_d  = off_c[MLEN+1:2];
          cnt_d   = CW'(WAIT);
          state_d = (WAIT == 0) ? READY : WAITING;
        end
      end
      WAITING: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = READY;
      end
      READY: begin
        datai_d = rdata_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rej_c) begin
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      if (bus.DRD & ~bus.DWR) datai_d = POISON;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      datai_q  <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      datai_q  <= datai_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  // RAM read is issued on the edge entering READY so its register holds the word there.
  assign re_c       = (state_d == READY);
  assign ram_addr_c = wr_ok_c ? off_c[MLEN+1:2] : addr_d;

  darkriscv_dmem_ram #(.MLEN(MLEN)) u_ram (
    .clk_i   (CLK),
    .we_i    (wr_ok_c),
    .be_i    (byte_en(bus.DLEN, bus.DADDR[1:0])),
    .re_i    (re_c),
    .addr_i  (ram_addr_c),
    .wdata_i (bus.DATAO),
    .rdata_o (rdata_c)
  );

  assign bus.HLT    = rd_ok_c | (RES & (state_q == WAITING));
  assign bus.DATAI  = (state_q == READY) ? rdata_c : datai_q;
  assign bus.ERR    = err_q;
  assign bus.ERRCNT = errcnt_q;

endmodule

// File: tb/tb_darkriscv_dmem_resp.sv
// Bench for darkriscv_dmem_resp: two instances (WAIT=2 and WAIT=0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_darkriscv_dmem_resp;
  localparam int unsigned MLEN = 10;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic        das, drd, dwr;
  logic [31:0] daddr, datao;
  logic [2:0]  dlen;
  int          sel;

  darkriscv_dmem_resp_if bus0 ();
  darkriscv_dmem_resp_if bus1 ();

  assign bus0.DAS = das && (sel == 0);
  assign bus0.DRD = drd;
  assign bus0.DWR = dwr;
  assign bus0.DADDR = daddr;
  assign bus0.DATAO = datao;
  assign bus0.DLEN = dlen;
  assign bus1.DAS = das && (sel == 1);
  assign bus1.DRD = drd;
  assign bus1.DWR = dwr;
  assign bus1.DADDR = daddr;
  assign bus1.DATAO = datao;
  assign bus1.DLEN = dlen;

  darkriscv_dmem_resp #(.MLEN(MLEN), .WAIT(2), .BASE(32'h0)) u0 (.CLK(clk), .RES(res), .bus(bus0));
  darkriscv_dmem_resp #(.MLEN(MLEN), .WAIT(0), .BASE(32'h0)) u1 (.CLK(clk), .RES(res), .bus(bus1));

  logic        hlt    [2];
  logic        err    [2];
  logic [31:0] datai  [2];
  logic [7:0]  errcnt [2];
  assign hlt[0] = bus0.HLT;    assign hlt[1] = bus1.HLT;
  assign err[0] = bus0.ERR;    assign err[1] = bus1.ERR;
  assign datai[0] = bus0.DATAI; assign datai[1] = bus1.DATAI;
  assign errcnt[0] = bus0.ERRCNT; assign errcnt[1] = bus1.ERRCNT;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] mem_m [int];
  int          rem_m [2];   // cycles left until the read returns to idle (READY when 1)
  logic [31:0] rd_m  [2];
  logic [31:0] dat_m [2];
  logic        err_m [2];
  int          cnt_m [2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int unsigned size_of(input logic [2:0] len);
    case (len)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [2:0] len);
    int unsigned sz = size_of(len);
    if (sz == 0) return 1'b0;
    if ((a % sz) != 0) return 1'b0;
    if (a >= 32'(4 << MLEN)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    return k * 65536 + int'(a >> 2);
  endfunction

  function automatic void model_write(input int k, input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] len);
    int          key = key_of(k, a);
    int unsigned lo = 32'(a[1:0]);
    int unsigned sz = size_of(len);
    logic [31:0] w = mem_m.exists(key) ? mem_m[key] : 32'hxxxx_xxxx;
    for (int unsigned i = lo; i < lo + sz; i++) w[8*i +: 8] = d[8*i +: 8];
    mem_m[key] = w;
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      for (int k = 0; k < 2; k++) begin
        rem_m[k] = 0; dat_m[k] = 32'h0; err_m[k] = 1'b0; cnt_m[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        err_m[k] = 1'b0;
        if (rem_m[k] > 0) begin
          rem_m[k]--;
          if (rem_m[k] == 1) dat_m[k] = rd_m[k];
        end else if (das && sel == k && (drd || dwr)) begin
          if (!(drd && dwr) && legal(daddr, dlen)) begin
            if (dwr) model_write(k, daddr, datao, dlen);
            else begin
              rd_m[k] = mem_m.exists(key_of(k, daddr)) ? mem_m[key_of(k, daddr)] : 32'hxxxx_xxxx;
              rem_m[k] = wait_of(k) + 1;
              if (rem_m[k] == 1) dat_m[k] = rd_m[k];
            end
          end else begin
            err_m[k] = 1'b1;
            if (cnt_m[k] < 255) cnt_m[k]++;
            if (drd && !dwr) dat_m[k] = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit eh;
      eh = (rem_m[k] > 1) ||
           (res && rem_m[k] == 0 && das && sel == k && drd && !dwr && legal(daddr, dlen));
      check($sformatf("hlt%0d", k), 32'(hlt[k]), 32'(eh));
      check($sformatf("err%0d", k), 32'(err[k]), 32'(err_m[k]));
      check($sformatf("errcnt%0d", k), 32'(errcnt[k]), 32'(cnt_m[k]));
      if (!$isunknown(dat_m[k])) check($sformatf("datai%0d", k), datai[k], dat_m[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    das = 1'b0; drd = 1'b0; dwr = 1'b0;
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
    sel = k; das = 1'b1; drd = 1'b0; dwr = 1'b1; daddr = a; datao = d; dlen = len;
    @(negedge clk);
    check("wr_nostall", 32'(hlt[k]), 32'h0);
    step();
    idle_bus();
  endtask

  task automatic do_op(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] len);
    sel = k; das = 1'b1; drd = rd; dwr = wr; daddr = a; datao = d; dlen = len;
    step();
    idle_bus();
  endtask

  // Issues a read and returns the data seen in the first non-stalled cycle.
  task automatic do_read(input int k, input logic [31:0] a, input bit noise,
                         output logic [31:0] d, output int st);
    bit done = 1'b0;
    sel = k; das = 1'b1; drd = 1'b1; dwr = 1'b0; daddr = a; dlen = 3'b100;
    st = 0; d = 32'h0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (hlt[k]) begin
        st++;
        step();
        if (noise) begin
          das = 1'b1; drd = 1'b0; dwr = 1'b1; datao = 32'hBAD0_BAD0;
        end else idle_bus();
      end else begin
        d = datai[k];
        done = 1'b1;
      end
    end
    check("read_done", 32'(done), 32'h1);
    step();
    idle_bus();
  endtask

  logic [31:0] rdat;
  int          rst_cnt;

  initial begin
    sel = 0; das = 1'b0; drd = 1'b0; dwr = 1'b0; daddr = 32'h0; datao = 32'h0; dlen = 3'b100;
    res = 1'b0;
    repeat (3) step();
    res = 1'b1;
    @(negedge clk);
    check("rst_hlt", 32'(hlt[0]), 32'h0);
    check("rst_datai", datai[0], 32'h0);
    check("rst_errcnt", 32'(errcnt[0]), 32'h0);
    step();

    // Strobe low with both request lines high: nothing happens.
    drd = 1'b1; dwr = 1'b1;
    repeat (10) step();
    idle_bus();
    check("das0_errcnt", 32'(errcnt[0]), 32'h0);

    // Word write/read, with a stray write driven during the stall.
    do_write(0, 32'h10, 32'h1234_5678, 3'b100);
    do_read(0, 32'h10, 1'b1, rdat, rst_cnt);
    check("w2_stall", 32'(rst_cnt), 32'd3);
    check("w2_data", rdat, 32'h1234_5678);

    // Byte and half lanes.
    do_write(0, 32'h20, 32'hFFFF_FFFF, 3'b100);
    do_write(0, 32'h21, 32'hAAAA_AAAA, 3'b001);
    do_write(0, 32'h22, 32'h5555_5555, 3'b010);
    do_read(0, 32'h20, 1'b0, rdat, rst_cnt);
    check("lanes_data", rdat, 32'h5555_AAFF);

    // Rejects.
    do_write(0, 32'h30, 32'hCAFE_F00D, 3'b100);
    do_op(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b100);
    @(negedge clk);
    check("rej_err", 32'(err[0]), 32'h1);
    check("rej_poison", datai[0], 32'hDEAD_BEEF);
    check("rej_cnt1", 32'(errcnt[0]), 32'd1);
    step();
    do_op(0, 1'b0, 1'b1, 32'h31, 32'h1111_1111, 3'b010);
    @(negedge clk);
    check("rej_cnt2", 32'(errcnt[0]), 32'd2);
    step();
    do_read(0, 32'h30, 1'b0, rdat, rst_cnt);
    check("rej_ram_kept", rdat, 32'hCAFE_F00D);
    do_op(0, 1'b1, 1'b1, 32'h30, 32'h0, 3'b100);
    @(negedge clk);
    check("rej_cnt3", 32'(errcnt[0]), 32'd3);
    step();
    do_op(0, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b100);
    do_op(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'b011);
    @(negedge clk);
    check("rej_cnt5", 32'(errcnt[0]), 32'd5);
    step();
    do_write(0, 32'hFFC, 32'h0F0F_0F0F, 3'b100);
    do_read(0, 32'hFFC, 1'b0, rdat, rst_cnt);
    check("top_word", rdat, 32'h0F0F_0F0F);

    // WAIT=0 instance: alternating reads and writes, read-after-write.
    do_write(1, 32'h40, 32'hA5A5_0001, 3'b100);
    do_read(1, 32'h40, 1'b0, rdat, rst_cnt);
    check("w0_stall", 32'(rst_cnt), 32'd1);
    check("w0_data1", rdat, 32'hA5A5_0001);
    do_write(1, 32'h44, 32'h0000_0002, 3'b100);
    do_read(1, 32'h44, 1'b0, rdat, rst_cnt);
    check("w0_data2", rdat, 32'h0000_0002);
    do_write(1, 32'h40, 32'h0000_0003, 3'b100);
    do_read(1, 32'h40, 1'b1, rdat, rst_cnt);
    check("w0_raw", rdat, 32'h0000_0003);
    check("w0_stall2", 32'(rst_cnt), 32'd1);
    check("w0_errcnt", 32'(errcnt[1]), 32'h0);

    // Reset during WAITING.
    sel = 0; das = 1'b1; drd = 1'b1; dwr = 1'b0; daddr = 32'h10; dlen = 3'b100;
    step();
    idle_bus();
    #1 res = 1'b0;
    #1 check("async_hlt", 32'(hlt[0]), 32'h0);
    step();
    step();
    res = 1'b1;
    @(negedge clk);
    check("post_rst_errcnt", 32'(errcnt[0]), 32'h0);
    check("post_rst_err", 32'(err[0]), 32'h0);
    step();
    do_read(0, 32'h10, 1'b0, rdat, rst_cnt);
    check("post_rst_data", rdat, 32'h1234_5678);
    check("post_rst_stall", 32'(rst_cnt), 32'd3);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
